// File: rtl/branch_redirect_ctrl.sv
// Resolves EX-stage branches and jumps. Issues a held redirect to fetch, flushes the front end,
// and raises misalignment and illegal-opcode pulses. Keeps branch and redirect statistics.
module branch_redirect_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned BJ_OP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [BJ_OP_W-1:0] ex_bj_op,
    input  logic               ex_b_taken,
    input  logic [XLEN-1:0]    ex_target,
    input  logic               redir_ready,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_pc,
    output logic               flush_front,
    output logic               hold_fetch,
    output logic               trap_misalign,
    output logic [XLEN-1:0]    trap_tval,
    output logic               illegal_bj,
    output logic [CNT_W-1:0]   br_cnt,
    output logic [CNT_W-1:0]   redir_cnt
);

    // EXE_BJOP_* encodings; codes above BGEU are undefined
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_NOOP = BJ_OP_W'(0);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_JUMP = BJ_OP_W'(1);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BEQ  = BJ_OP_W'(2);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BNE  = BJ_OP_W'(3);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BLT  = BJ_OP_W'(4);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BGE  = BJ_OP_W'(5);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BLTU = BJ_OP_W'(6);
    localparam logic [BJ_OP_W-1:0] EXE_BJOP_BGEU = BJ_OP_W'(7);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]    redir_pc_q, redir_pc_d;
    logic               flush_q, flush_d;
    logic               hold_q, hold_d;
    logic               trap_q, trap_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   redir_cnt_q, redir_cnt_d;

    logic op_defined;
    logic op_is_cond;
    logic op_taken;
    logic target_aligned;

    // Opcode decode; a jump is always taken whatever the condition unit reports
    always_comb begin
        op_defined     = (ex_bj_op <= EXE_BJOP_BGEU);
        op_is_cond     = (ex_bj_op >= EXE_BJOP_BEQ) && (ex_bj_op <= EXE_BJOP_BGEU);
        op_taken       = (ex_bj_op == EXE_BJOP_JUMP) || (op_is_cond && ex_b_taken);
        target_aligned = (ex_target[1:0] == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            hold_q        <= 1'b0;
            trap_q        <= 1'b0;
            tval_q        <= '0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            redir_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            hold_q        <= hold_d;
            trap_q        <= trap_d;
            tval_q        <= tval_d;
            illegal_q     <= illegal_d;
            br_cnt_q      <= br_cnt_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = flush_q;
        hold_d        = hold_q;
        trap_d        = 1'b0;
        tval_d        = tval_q;
        illegal_d     = 1'b0;
        br_cnt_d      = br_cnt_q;
        redir_cnt_d   = redir_cnt_q;

        unique case (state_q)
            IDLE: begin
                redir_valid_d = 1'b0;
                flush_d       = 1'b0;
                hold_d        = 1'b0;
                if (ex_valid) begin
                    if (!op_defined) begin
                        illegal_d = 1'b1;
                    end else if (ex_bj_op != EXE_BJOP_NOOP) begin
                        if (op_is_cond) begin
                            br_cnt_d = br_cnt_q + CNT_W'(1);
                        end
                        if (op_taken) begin
                            flush_d = 1'b1;
                            if (target_aligned) begin
                                state_d       = REDIR;
                                redir_valid_d = 1'b1;
                                redir_pc_d    = ex_target;
                                hold_d        = 1'b1;
                            end else begin
                                trap_d = 1'b1;
                                tval_d = ex_target;
                            end
                        end
                    end
                end
            end
            // EX contents are wrong-path here; only the fetch handshake matters
            REDIR: begin
                if (redir_ready) begin
                    state_d       = IDLE;
                    redir_valid_d = 1'b0;
                    flush_d       = 1'b0;
                    hold_d        = 1'b0;
                    redir_cnt_d   = redir_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign redir_valid   = redir_valid_q;
    assign redir_pc      = redir_pc_q;
    assign flush_front   = flush_q;
    assign hold_fetch    = hold_q;
    assign trap_misalign = trap_q;
    assign trap_tval     = tval_q;
    assign illegal_bj    = illegal_q;
    assign br_cnt        = br_cnt_q;
    assign redir_cnt     = redir_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed vectors push hand-computed expected outputs,
// and a negedge monitor compares each against the DUT after the edge it belongs to.
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] NOOP = 4'd0;
    localparam logic [3:0] JUMP = 4'd1;
    localparam logic [3:0] BEQ  = 4'd2;
    localparam logic [3:0] BNE  = 4'd3;
    localparam logic [3:0] BLT  = 4'd4;
    localparam logic [3:0] BGE  = 4'd5;
    localparam logic [3:0] BLTU = 4'd6;
    localparam logic [3:0] BGEU = 4'd7;

    logic             clk;
    logic             rst;
    logic             ex_valid;
    logic [3:0]       ex_bj_op;
    logic             ex_b_taken;
    logic [XLEN-1:0]  ex_target;
    logic             redir_ready;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_pc;
    logic             flush_front;
    logic             hold_fetch;
    logic             trap_misalign;
    logic [XLEN-1:0]  trap_tval;
    logic             illegal_bj;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] redir_cnt;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_bj_op     (ex_bj_op),
        .ex_b_taken   (ex_b_taken),
        .ex_target    (ex_target),
        .redir_ready  (redir_ready),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .flush_front  (flush_front),
        .hold_fetch   (hold_fetch),
        .trap_misalign(trap_misalign),
        .trap_tval    (trap_tval),
        .illegal_bj   (illegal_bj),
        .br_cnt       (br_cnt),
        .redir_cnt    (redir_cnt)
    );

    typedef struct {
        string       tag;
        int unsigned due;
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        hd;
        logic        tr;
        logic [31:0] tv;
        logic        il;
        logic [15:0] bc;
        logic [15:0] rc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h (cycle %0d)", tag, fld, act, exp, cyc);
        end
    endtask

    // Monitor: compare the entry whose committing edge has just passed
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.tag, "redir_valid", 32'(redir_valid), 32'(e.v));
            chk(e.tag, "redir_pc", redir_pc, e.pc);
            chk(e.tag, "flush_front", 32'(flush_front), 32'(e.fl));
            chk(e.tag, "hold_fetch", 32'(hold_fetch), 32'(e.hd));
            chk(e.tag, "trap_misalign", 32'(trap_misalign), 32'(e.tr));
            chk(e.tag, "trap_tval", trap_tval, e.tv);
            chk(e.tag, "illegal_bj", 32'(illegal_bj), 32'(e.il));
            chk(e.tag, "br_cnt", 32'(br_cnt), 32'(e.bc));
            chk(e.tag, "redir_cnt", 32'(redir_cnt), 32'(e.rc));
        end
    end

    // One cycle of stimulus plus the outputs expected after the following edge
    task automatic step(input string tag, input logic r, input logic ev, input logic [3:0] op,
                        input logic tk, input logic [31:0] tgt, input logic rdy,
                        input logic v, input logic [31:0] pc, input logic fl, input logic hd,
                        input logic tr, input logic [31:0] tv, input logic il,
                        input logic [15:0] bc, input logic [15:0] rc);
        exp_t e;
        rst         = r;
        ex_valid    = ev;
        ex_bj_op    = op;
        ex_b_taken  = tk;
        ex_target   = tgt;
        redir_ready = rdy;
        e.tag = tag; e.due = cyc + 1;
        e.v = v; e.pc = pc; e.fl = fl; e.hd = hd; e.tr = tr; e.tv = tv; e.il = il;
        e.bc = bc; e.rc = rc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1, 0, NOOP, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_bj_op = NOOP; ex_b_taken = 1'b0;
        ex_target = '0; redir_ready = 1'b0;
        @(posedge clk);
        #1;

        do_reset("reset");
        //         tag          rst ev op    tk tgt          rdy v  pc           fl hd tr tval         il br       rc
        step("beq_issue",   0, 1, BEQ,  1, 32'h1000, 0,  1, 32'h1000, 1, 1, 0, 32'h0,    0, 16'd1, 16'd0);
        step("beq_hold",    0, 0, NOOP, 0, 32'h0,    0,  1, 32'h1000, 1, 1, 0, 32'h0,    0, 16'd1, 16'd0);
        step("beq_accept",  0, 0, NOOP, 0, 32'h0,    1,  0, 32'h1000, 0, 0, 0, 32'h0,    0, 16'd1, 16'd1);
        step("beq_idle",    0, 0, NOOP, 0, 32'h0,    0,  0, 32'h1000, 0, 0, 0, 32'h0,    0, 16'd1, 16'd1);

        do_reset("reset2");
        step("bne_nt",      0, 1, BNE,  0, 32'h5000, 0,  0, 32'h0,    0, 0, 0, 32'h0,    0, 16'd1, 16'd0);
        step("stray_ready", 0, 0, NOOP, 0, 32'h0,    1,  0, 32'h0,    0, 0, 0, 32'h0,    0, 16'd1, 16'd0);

        do_reset("reset3");
        step("jmp_misal",   0, 1, JUMP, 0, 32'h1002, 0,  0, 32'h0,    1, 0, 1, 32'h1002, 0, 16'd0, 16'd0);
        step("misal_end",   0, 0, NOOP, 0, 32'h0,    0,  0, 32'h0,    0, 0, 0, 32'h1002, 0, 16'd0, 16'd0);
        step("bge_misal",   0, 1, BGE,  1, 32'h3001, 0,  0, 32'h0,    1, 0, 1, 32'h3001, 0, 16'd1, 16'd0);
        step("blt_misal",   0, 1, BLT,  1, 32'h3002, 0,  0, 32'h0,    1, 0, 1, 32'h3002, 0, 16'd2, 16'd0);
        step("trap_end",    0, 0, NOOP, 0, 32'h0,    0,  0, 32'h0,    0, 0, 0, 32'h3002, 0, 16'd2, 16'd0);
        step("illegal_a",   0, 1, 4'hA, 1, 32'h4000, 0,  0, 32'h0,    0, 0, 0, 32'h3002, 1, 16'd2, 16'd0);
        step("illegal_f",   0, 1, 4'hF, 1, 32'h4000, 0,  0, 32'h0,    0, 0, 0, 32'h3002, 1, 16'd2, 16'd0);
        step("noop_taken",  0, 1, NOOP, 1, 32'h0100, 0,  0, 32'h0,    0, 0, 0, 32'h3002, 0, 16'd2, 16'd0);
        step("ev_low",      0, 0, BEQ,  1, 32'h0200, 0,  0, 32'h0,    0, 0, 0, 32'h3002, 0, 16'd2, 16'd0);

        do_reset("reset4");
        step("jmp_2000",    0, 1, JUMP, 0, 32'h2000, 0,  1, 32'h2000, 1, 1, 0, 32'h0,    0, 16'd0, 16'd0);
        for (int i = 0; i < 5; i++)
            step("redir_ignore", 0, 1, BEQ, 1, 32'h3000, 0, 1, 32'h2000, 1, 1, 0, 32'h0, 0, 16'd0, 16'd0);
        step("exit_same",   0, 1, BEQ,  1, 32'h3000, 1,  0, 32'h2000, 0, 0, 0, 32'h0,    0, 16'd0, 16'd1);
        step("after_exit",  0, 0, NOOP, 0, 32'h0,    0,  0, 32'h2000, 0, 0, 0, 32'h0,    0, 16'd0, 16'd1);

        do_reset("reset5");
        step("jmp_800",     0, 1, JUMP, 1, 32'h0800, 0,  1, 32'h0800, 1, 1, 0, 32'h0,    0, 16'd0, 16'd0);
        step("rst_in_redir",1, 1, BEQ,  1, 32'h0900, 1,  0, 32'h0,    0, 0, 0, 32'h0,    0, 16'd0, 16'd0);
        step("bltu_40",     0, 1, BLTU, 1, 32'h0040, 0,  1, 32'h0040, 1, 1, 0, 32'h0,    0, 16'd1, 16'd0);
        step("bltu_accept", 0, 0, NOOP, 0, 32'h0,    1,  0, 32'h0040, 0, 0, 0, 32'h0,    0, 16'd1, 16'd1);

        do_reset("reset6");
        for (int i = 1; i <= 65535; i++)
            step("blt_preload", 0, 1, BLT, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 16'(i), 16'd0);
        step("bgeu_wrap",   0, 1, BGEU, 0, 32'h0,    0,  0, 32'h0,    0, 0, 0, 32'h0,    0, 16'h0000, 16'd0);
        step("bge_after",   0, 1, BGE,  0, 32'h0,    0,  0, 32'h0,    0, 0, 0, 32'h0,    0, 16'h0001, 16'd0);

        ex_valid = 1'b0;
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 32, width of PC and target buses.
REQ-002 Parameter CNT_W, default 16, width of statistics counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ex_valid  in  1  EX stage holds a valid instruction this cycle.
REQ-006 ex_bj_op  in  `BJ_OP_BUS  branch/jump opcode of the EX instruction (EXE_BJOP_* codes).
REQ-007 ex_b_taken  in  1  branch/jump condition result from the jump_control unit.
REQ-008 ex_target  in  XLEN  computed branch/jump target address.
REQ-009 redir_ready  in  1  fetch unit accepts the redirect this cycle.
REQ-010 redir_valid  out  1  redirect request to fetch.
REQ-011 redir_pc  out  XLEN  redirect address, valid while redir_valid=1.
REQ-012 flush_front  out  1  kill IF/ID and ID/EX contents (wrong-path instructions).
REQ-013 hold_fetch  out  1  freeze PC update in fetch while a redirect is outstanding.
REQ-014 trap_misalign  out  1  one-cycle pulse: taken target not 4-byte aligned.
REQ-015 trap_tval  out  XLEN  offending target, valid when trap_misalign=1, held until next trap.
REQ-016 illegal_bj  out  1  one-cycle pulse: ex_bj_op not a defined EXE_BJOP_* code.
REQ-017 br_cnt  out  CNT_W  count of resolved conditional branches (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-018 redir_cnt  out  CNT_W  count of redirects accepted by fetch.

Function
REQ-019 The controller SHALL implement states IDLE and REDIR; all outputs SHALL be registered.
REQ-020 "Resolve event" SHALL mean state=IDLE, ex_valid=1, ex_bj_op a defined code other than EXE_BJOP_NOOP.
REQ-021 On a resolve event with ex_b_taken=1 and ex_target[1:0]=2'b00: latch ex_target into redir_pc, go to REDIR; redir_valid, flush_front, hold_fetch SHALL be 1 the next cycle (latency 1).
REQ-022 On a resolve event with ex_b_taken=1 and ex_target[1:0]!=0: stay in IDLE; trap_misalign=1 and trap_tval=ex_target the next cycle; flush_front=1 the same next cycle; no redirect issued.
REQ-023 On a resolve event with ex_b_taken=0: no state change, no flush, no redirect.
REQ-024 In REDIR, redir_valid, redir_pc, flush_front, hold_fetch SHALL remain 1/stable every cycle until a cycle with redir_ready=1.
REQ-025 In REDIR with redir_ready=1: go to IDLE; redir_valid, flush_front, hold_fetch SHALL be 0 the next cycle; redir_cnt increments by 1.
REQ-026 In REDIR, ex_valid and all ex_* inputs SHALL be ignored (wrong-path instructions): no counting, no traps, no illegal_bj.
REQ-027 redir_ready while redir_valid=0 SHALL have no effect.
REQ-028 In IDLE with ex_valid=1 and undefined ex_bj_op: illegal_bj=1 next cycle; treated as not taken; ex_b_taken ignored.
REQ-029 br_cnt SHALL increment on each resolve event whose opcode is a conditional branch, taken or not, including misaligned-target cases.
REQ-030 EXE_BJOP_JUMP SHALL not increment br_cnt; it SHALL redirect per REQ-021/022 regardless of ex_b_taken.
REQ-031 Counters SHALL wrap modulo 2^CNT_W (0xFFFF + 1 -> 0x0000 at default).
REQ-032 trap_misalign and illegal_bj SHALL be exactly one cycle wide per event; back-to-back events SHALL produce back-to-back pulses.
REQ-033 A resolve event arriving in the same cycle that REDIR exits SHALL be ignored (state was REDIR at the edge).

Reset
REQ-034 When rst=1 at a clock edge: state=IDLE; redir_valid, flush_front, hold_fetch, trap_misalign, illegal_bj = 0; redir_pc, trap_tval = 0; br_cnt, redir_cnt = 0.
REQ-035 rst SHALL take priority over all inputs; reset during REDIR SHALL abandon the redirect without incrementing redir_cnt.

Verification
REQ-036 BEQ, ex_b_taken=1, target 0x0000_1000, redir_ready=1 two cycles later -> redir_valid=1 with redir_pc=0x1000 for 2 cycles, then 0; redir_cnt=1; br_cnt=1.
REQ-037 BNE, ex_b_taken=0 -> no redir_valid, no flush; br_cnt=1; redir_cnt=0.
REQ-038 JUMP, target 0x0000_1002 -> trap_misalign pulse, trap_tval=0x1002, flush_front 1 cycle, redir_valid stays 0; br_cnt=0.
REQ-039 JUMP to 0x2000, redir_ready=0 for 5 cycles while ex_valid=1 with BEQ taken to 0x3000 -> redir_pc stays 0x2000; br_cnt unchanged; after ready, redir_cnt=1.
REQ-040 Preload br_cnt=0xFFFF via 65535 BLT resolves, then one BGEU -> br_cnt=0x0000.
REQ-041 Assert rst during REDIR -> next cycle all outputs 0, state IDLE; following taken BLTU to 0x40 redirects normally.
